// File: rtl/sha256_block_engine.sv
// SHA-256 block compression engine: one 512-bit block per request, one round per clock,
// with internal chaining across the blocks of HEADER and MERKLE_LEAF messages.
module sha256_block_engine (
  input  logic         sys_clk,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] msg,
  input  logic [1:0]   blk_type,
  output logic [255:0] hash,
  output logic         blk_done,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] TYPE_HASH    = 2'b00;
  localparam logic [1:0] TYPE_INVALID = 2'b11;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    logic [63:0] dbl;
    dbl = {x, x} >> n;
    return dbl[31:0];
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t      state_reg, state_next;
  logic [31:0] w_reg     [16];
  logic [31:0] w_next    [16];
  logic [31:0] work_reg  [8];
  logic [31:0] work_next [8];
  logic [31:0] base_reg  [8];
  logic [31:0] base_next [8];
  logic [31:0] hash_reg  [8];
  logic [31:0] hash_next [8];
  logic [5:0]  t_reg, t_next;
  logic [1:0]  blk_idx_reg, blk_idx_next;
  logic [1:0]  cur_type_reg, cur_type_next;
  logic        blk_done_reg, blk_done_next;
  logic        busy_reg, busy_next;

  logic [31:0] msg_word  [16];
  logic [31:0] final_sum [8];
  logic [31:0] k_t, w_new, ch_val, maj_val, t1, t2;
  logic [1:0]  blk_count, blk_idx_inc;
  logic        accept, new_msg;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_msg_unpack
      assign msg_word[gi] = msg[511 - 32*gi -: 32];
    end
    for (gi = 0; gi < 8; gi++) begin : g_hash_pack
      assign hash[255 - 32*gi -: 32] = hash_reg[gi];
      assign final_sum[gi]           = base_reg[gi] + work_reg[gi];
    end
  endgenerate

  // Round datapath: work_reg[0..7] hold a..h, w_reg[0] is W[t].
  assign k_t     = K_ROM[t_reg];
  assign ch_val  = (work_reg[4] & work_reg[5]) ^ (~work_reg[4] & work_reg[6]);
  assign maj_val = (work_reg[0] & work_reg[1]) ^ (work_reg[0] & work_reg[2]) ^ (work_reg[1] & work_reg[2]);
  assign t1      = work_reg[7] + big_sigma1(work_reg[4]) + ch_val + k_t + w_reg[0];
  assign t2      = big_sigma0(work_reg[0]) + maj_val;
  assign w_new   = small_sigma1(w_reg[14]) + w_reg[9] + small_sigma0(w_reg[1]) + w_reg[0];

  assign accept      = start && (blk_type != TYPE_INVALID);
  // A change of message type abandons any partially chained message.
  assign new_msg     = (blk_idx_reg == 2'd0) || (blk_type != cur_type_reg);
  assign blk_count   = (cur_type_reg == TYPE_HASH) ? 2'd1 : 2'd2;
  assign blk_idx_inc = blk_idx_reg + 2'd1;

  always_comb begin
    state_next    = state_reg;
    w_next        = w_reg;
    work_next     = work_reg;
    base_next     = base_reg;
    hash_next     = hash_reg;
    t_next        = t_reg;
    blk_idx_next  = blk_idx_reg;
    cur_type_next = cur_type_reg;
    blk_done_next = blk_done_reg;
    busy_next     = busy_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next    = ST_ROUND;
          busy_next     = 1'b1;
          t_next        = 6'd0;
          cur_type_next = blk_type;
          if (new_msg) begin
            blk_idx_next = 2'd0;
          end
          for (int i = 0; i < 16; i++) begin
            w_next[i] = msg_word[i];
          end
          for (int i = 0; i < 8; i++) begin
            base_next[i] = new_msg ? IV[i] : hash_reg[i];
            work_next[i] = new_msg ? IV[i] : hash_reg[i];
          end
        end
      end
      ST_ROUND: begin
        for (int i = 0; i < 15; i++) begin
          w_next[i] = w_reg[i + 1];
        end
        w_next[15]   = w_new;
        work_next[0] = t1 + t2;
        work_next[1] = work_reg[0];
        work_next[2] = work_reg[1];
        work_next[3] = work_reg[2];
        work_next[4] = work_reg[3] + t1;
        work_next[5] = work_reg[4];
        work_next[6] = work_reg[5];
        work_next[7] = work_reg[6];
        t_next       = t_reg + 6'd1;
        if (t_reg == 6'd63) begin
          state_next = ST_FINAL;
        end
      end
      ST_FINAL: begin
        hash_next     = final_sum;
        blk_done_next = 1'b1;
        blk_idx_next  = (blk_idx_inc == blk_count) ? 2'd0 : blk_idx_inc;
        state_next    = ST_DONE;
      end
      ST_DONE: begin
        blk_done_next = 1'b0;
        busy_next     = 1'b0;
        state_next    = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      blk_idx_reg  <= 2'd0;
      cur_type_reg <= TYPE_INVALID;
      blk_done_reg <= 1'b0;
      busy_reg     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        hash_reg[i] <= 32'd0;
      end
    end else begin
      state_reg    <= state_next;
      blk_idx_reg  <= blk_idx_next;
      cur_type_reg <= cur_type_next;
      blk_done_reg <= blk_done_next;
      busy_reg     <= busy_next;
      hash_reg     <= hash_next;
    end
  end

  // Working state needs no reset: it is always reloaded on accept.
  always_ff @(posedge sys_clk) begin
    w_reg    <= w_next;
    work_reg <= work_next;
    base_reg <= base_next;
    t_reg    <= t_next;
  end

  assign blk_done = blk_done_reg;
  assign busy     = busy_reg;

endmodule
